// File: rtl/mux_pkg.sv
// Shared definitions for the mux_rr channel multiplexer.
// Exports: MODE_DIRECT/MODE_RR mode codes and a clog2 helper.
package mux_pkg;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_RR     = 1'b1;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotate-priority encoder: first set req at or after ptr.
// Ports: req (requests), ptr (start index) -> gnt_idx (winner), gnt_vld.
module rr_arbiter
    import mux_pkg::*;
#(
    parameter  int N_CH  = 4,
    localparam int SEL_W = clog2(N_CH)
) (
    input  logic [N_CH-1:0]  req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] gnt_idx,
    output logic             gnt_vld
);

    int w_idx;

    // Walk offsets from farthest to nearest so the nearest hit wins.
    always_comb begin
        gnt_idx = '0;
        gnt_vld = 1'b0;
        w_idx   = 0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            w_idx = int'(ptr) + i;
            if (w_idx >= N_CH) w_idx = w_idx - N_CH;
            if (req[w_idx[SEL_W-1:0]]) begin
                gnt_idx = w_idx[SEL_W-1:0];
                gnt_vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_rr.sv
// N-channel registered mux, direct-select or round-robin, with handshake.
// Ports: clk, reset (sync, active-low), mode, sel, data_in, valid_in,
//        ready_out, data_out, ch_out, valid_out, ready_in.
module mux_rr
    import mux_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int N_CH  = 4,
    localparam int SEL_W = clog2(N_CH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  mode,
    input  logic [SEL_W-1:0]      sel,
    input  logic [N_CH*WIDTH-1:0] data_in,
    input  logic [N_CH-1:0]       valid_in,
    output logic [N_CH-1:0]       ready_out,
    output logic [WIDTH-1:0]      data_out,
    output logic [SEL_W-1:0]      ch_out,
    output logic                  valid_out,
    input  logic                  ready_in
);

    logic [WIDTH-1:0] r_data;
    logic [SEL_W-1:0] r_ch;
    logic             r_valid;
    logic [SEL_W-1:0] r_ptr;

    logic [SEL_W-1:0] w_rr_gnt;
    logic             w_rr_vld;
    logic [SEL_W-1:0] w_gnt;
    logic             w_gnt_ok;
    logic             w_req;
    logic             w_can_load;
    logic             w_load;
    logic [WIDTH-1:0] w_data;
    logic [N_CH-1:0]  w_ready;

    rr_arbiter #(.N_CH(N_CH)) u_arb (
        .req     (valid_in),
        .ptr     (r_ptr),
        .gnt_idx (w_rr_gnt),
        .gnt_vld (w_rr_vld)
    );

    assign w_can_load = !r_valid || ready_in;

    // Direct mode grants sel even without a request, so ready_out
    // advertises room on that channel; a load still needs valid_in.
    always_comb begin
        w_gnt    = '0;
        w_gnt_ok = 1'b0;
        w_req    = 1'b0;
        if (mode == MODE_RR) begin
            w_gnt    = w_rr_gnt;
            w_gnt_ok = w_rr_vld;
            w_req    = w_rr_vld;
        end else if (int'(sel) < N_CH) begin
            w_gnt    = sel;
            w_gnt_ok = 1'b1;
            w_req    = valid_in[sel];
        end
    end

    assign w_load = reset && w_req && w_can_load;

    always_comb begin
        w_data = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (w_gnt == SEL_W'(k)) w_data = data_in[k*WIDTH +: WIDTH];
        end
    end

    always_comb begin
        w_ready = '0;
        if (reset && w_gnt_ok && w_can_load) w_ready[w_gnt] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_data  <= '0;
            r_ch    <= '0;
            r_valid <= 1'b0;
            r_ptr   <= '0;
        end else begin
            if (w_load) begin
                r_data  <= w_data;
                r_ch    <= w_gnt;
                r_valid <= 1'b1;
            end else if (ready_in) begin
                r_valid <= 1'b0;
            end
            if (w_load && mode == MODE_RR) begin
                r_ptr <= (int'(w_gnt) == N_CH - 1) ? '0 : w_gnt + 1'b1;
            end
        end
    end

    assign ready_out = w_ready;
    assign data_out  = r_data;
    assign ch_out    = r_ch;
    assign valid_out = r_valid;

endmodule

// File: tb/tb_mux_rr.sv
// Self-checking bench for mux_rr: directed scenarios plus random traffic.
// Reference model tracks the held word and scan pointer arithmetically.
module tb_mux_rr;

    localparam int WIDTH = 8;
    localparam int N_CH  = 4;
    localparam int SEL_W = 2;

    logic                  clk = 1'b0;
    logic                  reset = 1'b0;
    logic                  mode = 1'b0;
    logic [SEL_W-1:0]      sel = '0;
    logic [N_CH*WIDTH-1:0] data_in = '0;
    logic [N_CH-1:0]       valid_in = '0;
    logic [N_CH-1:0]       ready_out;
    logic [WIDTH-1:0]      data_out;
    logic [SEL_W-1:0]      ch_out;
    logic                  valid_out;
    logic                  ready_in = 1'b0;

    int n_chk = 0;
    int n_fail = 0;

    int m_valid = 0;
    int m_data = 0;
    int m_ch = 0;
    int m_ptr = 0;

    always #5 clk = ~clk;

    mux_rr #(.WIDTH(WIDTH), .N_CH(N_CH)) dut (
        .clk       (clk),
        .reset     (reset),
        .mode      (mode),
        .sel       (sel),
        .data_in   (data_in),
        .valid_in  (valid_in),
        .ready_out (ready_out),
        .data_out  (data_out),
        .ch_out    (ch_out),
        .valid_out (valid_out),
        .ready_in  (ready_in)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Channel the spec's rules would grant this cycle, or -1.
    function automatic int model_gnt();
        if (!reset) return -1;
        if (mode == 1'b0) return (int'(sel) < N_CH) ? int'(sel) : -1;
        for (int i = 0; i < N_CH; i++) begin
            if (valid_in[(m_ptr + i) % N_CH]) return (m_ptr + i) % N_CH;
        end
        return -1;
    endfunction

    task automatic put(input int k, input int v);
        data_in[k*WIDTH +: WIDTH] = WIDTH'(v);
    endtask

    // Check outputs against the model, then advance model and DUT one clock.
    task automatic cyc();
        int g;
        int cl;
        int er;
        @(negedge clk);
        chk("valid_out", int'(valid_out), m_valid);
        chk("data_out", int'(data_out), m_data);
        chk("ch_out", int'(ch_out), m_ch);
        g  = model_gnt();
        cl = (m_valid == 0 || ready_in) ? 1 : 0;
        er = (g >= 0 && cl == 1) ? (1 << g) : 0;
        chk("ready_out", int'(ready_out), er);
        if (!reset) begin
            m_valid = 0; m_data = 0; m_ch = 0; m_ptr = 0;
        end else if (g >= 0 && valid_in[g] && cl == 1) begin
            m_valid = 1;
            m_data  = int'((data_in >> (g * WIDTH)) & 32'hFF);
            m_ch    = g;
            if (mode) m_ptr = (g + 1) % N_CH;
        end else if (ready_in) begin
            m_valid = 0;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset held with all channels requesting.
        reset = 1'b0; mode = 1'b1; valid_in = 4'hF; ready_in = 1'b1;
        data_in = 32'h44332211;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", int'(valid_out), 0);
        chk("rst_data", int'(data_out), 0);
        chk("rst_ch", int'(ch_out), 0);
        chk("rst_ready", int'(ready_out), 0);
        cyc();

        // Direct select of channel 2.
        reset = 1'b1; mode = 1'b0; sel = 2'd2; valid_in = 4'b0100;
        put(2, 8'hA5);
        #1;
        chk("dir_ready", int'(ready_out), 4'b0100);
        cyc();
        chk("dir_data", int'(data_out), 8'hA5);
        chk("dir_ch", int'(ch_out), 2);
        chk("dir_valid", int'(valid_out), 1);

        // Round-robin over all channels, wrap 3->0.
        mode = 1'b1; valid_in = 4'hF;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("rr_seq", int'(ch_out), i % N_CH);
        end

        // Idle channels skipped, starting from pointer 1.
        valid_in = 4'b0001;
        cyc();
        valid_in = 4'b1001;
        cyc();
        chk("skip_a", int'(ch_out), 3);
        cyc();
        chk("skip_b", int'(ch_out), 0);
        cyc();
        chk("skip_c", int'(ch_out), 3);

        // Backpressure hold then drain-and-load.
        mode = 1'b0; sel = 2'd1; valid_in = 4'b0010; put(1, 8'h3C);
        cyc();
        ready_in = 1'b0; put(1, 8'h55);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_ready", int'(ready_out), 0);
            cyc();
            chk("bp_data", int'(data_out), 8'h3C);
            chk("bp_valid", int'(valid_out), 1);
        end
        ready_in = 1'b1; put(1, 8'h77);
        #1;
        chk("dl_ready", int'(ready_out), 4'b0010);
        cyc();
        chk("dl_data", int'(data_out), 8'h77);
        chk("dl_valid", int'(valid_out), 1);

        // Reset mid-stream restarts the scan at channel 0.
        mode = 1'b1; valid_in = 4'hF;
        cyc();
        cyc();
        reset = 1'b0;
        cyc();
        chk("mid_rst_valid", int'(valid_out), 0);
        reset = 1'b1;
        cyc();
        chk("mid_rst_ch", int'(ch_out), 0);
        chk("mid_rst_v", int'(valid_out), 1);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            reset    = ($urandom % 32) != 0;
            mode     = 1'($urandom);
            sel      = SEL_W'($urandom);
            valid_in = N_CH'($urandom);
            ready_in = ($urandom % 4) != 0;
            data_in  = $urandom;
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
